// File: rtl/tlul_pkg.sv
// Shared TL-UL encodings and the response-entry metadata kept per outstanding request.
package tlul_pkg;

   localparam logic [2:0] OP_PUT_FULL        = 3'd0;
   localparam logic [2:0] OP_PUT_PARTIAL     = 3'd1;
   localparam logic [2:0] OP_GET             = 3'd4;
   localparam logic [2:0] OP_ACCESS_ACK      = 3'd0;
   localparam logic [2:0] OP_ACCESS_ACK_DATA = 3'd1;

   typedef struct packed {
      logic [2:0] opcode;
      logic [1:0] size;
      logic       err;
      logic       is_read;
   } rsp_meta_t;

   // Size 3 is rejected separately, so only half-word and word alignment matter here.
   function automatic logic addr_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      logic r;
      r = 1'b0;
      if (size == 2'd1) r = addr_lo[0];
      if (size == 2'd2) r = |addr_lo;
      return r;
   endfunction

endpackage

// File: rtl/tlul_rsp_fifo.sv
// In-order response store; read entries wait for late data through an indexed write port.
module tlul_rsp_fifo
   import tlul_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned SRC_W = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  rsp_meta_t                push_meta_i,
   input  logic [SRC_W-1:0]         push_src_i,
   output logic [$clog2(DEPTH)-1:0] wptr_o,
   input  logic                     dwr_i,
   input  logic [$clog2(DEPTH)-1:0] dwr_idx_i,
   input  logic [31:0]              dwr_data_i,
   input  logic                     pop_i,
   output logic                     not_full_o,
   output logic                     head_ok_o,
   output rsp_meta_t                head_meta_o,
   output logic [SRC_W-1:0]         head_src_o,
   output logic [31:0]              head_data_o
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   rsp_meta_t        meta_q [DEPTH];
   logic [SRC_W-1:0] src_q  [DEPTH];
   logic [31:0]      data_q [DEPTH];
   logic [DEPTH-1:0] ok_q;
   logic [PW-1:0]    wptr_q, rptr_q;
   logic [CW-1:0]    count_q, count_d;
   logic             not_full_q;

   always_comb begin
      count_d = count_q;
      if (push_i && !pop_i) count_d = count_q + 1'b1;
      if (pop_i && !push_i) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         not_full_q <= 1'b0;
         ok_q       <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            meta_q[i] <= '0;
            src_q[i]  <= '0;
            data_q[i] <= '0;
         end
      end else begin
         count_q    <= count_d;
         // Registered from next count: a pop on a full FIFO opens the slot a cycle later.
         not_full_q <= count_d < DEPTH_C;
         if (push_i) begin
            meta_q[wptr_q] <= push_meta_i;
            src_q[wptr_q]  <= push_src_i;
            data_q[wptr_q] <= '0;
            ok_q[wptr_q]   <= !push_meta_i.is_read;
            wptr_q         <= wptr_q + 1'b1;
         end
         if (dwr_i) begin
            data_q[dwr_idx_i] <= dwr_data_i;
            ok_q[dwr_idx_i]   <= 1'b1;
         end
         if (pop_i) begin
            ok_q[rptr_q] <= 1'b0;
            rptr_q       <= rptr_q + 1'b1;
         end
      end
   end

   assign wptr_o      = wptr_q;
   assign not_full_o  = not_full_q;
   assign head_ok_o   = ok_q[rptr_q];
   assign head_meta_o = meta_q[rptr_q];
   assign head_src_o  = src_q[rptr_q];
   assign head_data_o = data_q[rptr_q];

endmodule

// File: rtl/tlul_instr_mem_adapter.sv
// TL-UL device adapter in front of the instruction SRAM: decodes A requests, drives the
// memory port and returns in-order D responses, acking writes and errors locally.
module tlul_instr_mem_adapter
   import tlul_pkg::*;
#(
   parameter int unsigned MEM_AW    = 12,
   parameter int unsigned SRC_W     = 8,
   parameter int unsigned RSP_DEPTH = 2
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              a_valid_i,
   output logic              a_ready_o,
   input  logic [2:0]        a_opcode_i,
   input  logic [1:0]        a_size_i,
   input  logic [31:0]       a_address_i,
   input  logic [3:0]        a_mask_i,
   input  logic [31:0]       a_data_i,
   input  logic [SRC_W-1:0]  a_source_i,
   output logic              d_valid_o,
   input  logic              d_ready_i,
   output logic [2:0]        d_opcode_o,
   output logic [1:0]        d_size_o,
   output logic [SRC_W-1:0]  d_source_o,
   output logic [31:0]       d_data_o,
   output logic              d_error_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [MEM_AW-1:0] mem_addr_o,
   output logic [31:0]       mem_wdata_o,
   output logic [3:0]        mem_wmask_o,
   input  logic [31:0]       mem_rdata_i,
   input  logic              mem_rvalid_i
);
   localparam int unsigned PW = $clog2(RSP_DEPTH);

   logic             accept, is_get, req_err;
   logic [PW-1:0]    wptr, rd_idx_q, rd_idx_d;
   logic             rd_pend_q, rd_pend_d, orphan_q, orphan_d;
   rsp_meta_t        push_meta, head_meta;
   logic [SRC_W-1:0] head_src;
   logic [31:0]      head_data;
   logic             head_ok;

   always_comb begin
      is_get  = a_opcode_i == OP_GET;
      req_err = !(is_get || a_opcode_i == OP_PUT_FULL || a_opcode_i == OP_PUT_PARTIAL)
                || (a_size_i == 2'd3)
                || addr_misaligned(a_size_i, a_address_i[1:0])
                || (|a_address_i[31:MEM_AW+2])
                || (a_opcode_i == OP_PUT_FULL && a_size_i == 2'd2 && a_mask_i != 4'hF);
      accept  = a_valid_i && a_ready_o;

      mem_req_o   = accept && !req_err;
      mem_we_o    = mem_req_o && !is_get;
      mem_addr_o  = a_address_i[MEM_AW+1:2];
      mem_wdata_o = a_data_i;
      mem_wmask_o = is_get ? 4'h0 : a_mask_i;

      push_meta.opcode  = is_get ? OP_ACCESS_ACK_DATA : OP_ACCESS_ACK;
      push_meta.size    = a_size_i;
      push_meta.err     = req_err;
      push_meta.is_read = is_get && !req_err;

      // Memory latency is fixed at one cycle, so only last cycle's read can be pending.
      rd_pend_d = mem_req_o && !mem_we_o;
      rd_idx_d  = rd_pend_d ? wptr : rd_idx_q;
      orphan_d  = orphan_q || (mem_rvalid_i && !rd_pend_q);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_pend_q <= 1'b0;
         rd_idx_q  <= '0;
         orphan_q  <= 1'b0;
      end else begin
         rd_pend_q <= rd_pend_d;
         rd_idx_q  <= rd_idx_d;
         orphan_q  <= orphan_d;
      end
   end

   tlul_rsp_fifo #(
      .DEPTH (RSP_DEPTH),
      .SRC_W (SRC_W)
   ) u_fifo (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .push_i      (accept),
      .push_meta_i (push_meta),
      .push_src_i  (a_source_i),
      .wptr_o      (wptr),
      .dwr_i       (mem_rvalid_i && rd_pend_q),
      .dwr_idx_i   (rd_idx_q),
      .dwr_data_i  (mem_rdata_i),
      .pop_i       (d_valid_o && d_ready_i),
      .not_full_o  (a_ready_o),
      .head_ok_o   (head_ok),
      .head_meta_o (head_meta),
      .head_src_o  (head_src),
      .head_data_o (head_data)
   );

   assign d_valid_o  = head_ok;
   assign d_opcode_o = head_meta.opcode;
   assign d_size_o   = head_meta.size;
   assign d_source_o = head_src;
   assign d_error_o  = head_meta.err;
   assign d_data_o   = head_meta.is_read ? head_data : 32'h0;

   // Stray read data is dropped; the sticky flag exposes it.
   a_no_orphan_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni) !orphan_q);

endmodule

// File: tb/tb_tlul_instr_mem_adapter.sv
// Scoreboard bench for tlul_instr_mem_adapter with a 1-cycle SRAM model behind it.
module tb_tlul_instr_mem_adapter;
   localparam int MEM_AW = 12;

   logic        clk_i = 0, rst_ni = 0;
   logic        a_valid_i = 0, a_ready_o;
   logic [2:0]  a_opcode_i = 0;
   logic [1:0]  a_size_i = 0;
   logic [31:0] a_address_i = 0, a_data_i = 0;
   logic [3:0]  a_mask_i = 0;
   logic [7:0]  a_source_i = 0;
   logic        d_valid_o, d_ready_i = 1, d_error_o;
   logic [2:0]  d_opcode_o;
   logic [1:0]  d_size_o;
   logic [7:0]  d_source_o;
   logic [31:0] d_data_o;
   logic        mem_req_o, mem_we_o, mem_rvalid_i;
   logic [MEM_AW-1:0] mem_addr_o;
   logic [31:0] mem_wdata_o, mem_rdata_i;
   logic [3:0]  mem_wmask_o;

   tlul_instr_mem_adapter #(.MEM_AW(MEM_AW), .SRC_W(8), .RSP_DEPTH(2)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .a_valid_i(a_valid_i), .a_ready_o(a_ready_o), .a_opcode_i(a_opcode_i), .a_size_i(a_size_i),
      .a_address_i(a_address_i), .a_mask_i(a_mask_i), .a_data_i(a_data_i), .a_source_i(a_source_i),
      .d_valid_o(d_valid_o), .d_ready_i(d_ready_i), .d_opcode_o(d_opcode_o), .d_size_o(d_size_o),
      .d_source_o(d_source_o), .d_data_o(d_data_o), .d_error_o(d_error_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_wmask_o(mem_wmask_o), .mem_rdata_i(mem_rdata_i), .mem_rvalid_i(mem_rvalid_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [2:0]  op;
      logic [1:0]  sz;
      logic [7:0]  src;
      logic [31:0] data;
      logic        err;
      bit          lat_chk;
      int          lat;
      int          t0;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] sram   [4096];
   logic [31:0] shadow [4096];
   int          n_cmp = 0, n_bad = 0, cyc = 0;
   bit          rnd_on = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // SRAM stand-in: registered read data, rvalid one cycle after a read request.
   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_rvalid_i <= 1'b0;
         mem_rdata_i  <= '0;
      end else begin
         mem_rvalid_i <= mem_req_o && !mem_we_o;
         if (mem_req_o && mem_we_o) begin
            for (int b = 0; b < 4; b++)
               if (mem_wmask_o[b]) sram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
         end else if (mem_req_o) begin
            mem_rdata_i <= sram[mem_addr_o];
         end
      end
   end

   always @(posedge clk_i) cyc++;

   always @(posedge clk_i) if (rnd_on) begin
      #1 d_ready_i = ($urandom_range(0, 3) != 0);
   end

   always @(negedge clk_i) begin
      exp_t e;
      if (rst_ni && d_valid_o && d_ready_i) begin
         if (sb.size() == 0) check("d_unexpected", 1, 0);
         else begin
            e = sb.pop_front();
            check("d_opcode", d_opcode_o, e.op);
            check("d_size",   d_size_o,   e.sz);
            check("d_source", d_source_o, e.src);
            check("d_error",  d_error_o,  e.err);
            check("d_data",   d_data_o,   e.data);
            if (e.lat_chk) check("d_latency", cyc - e.t0, e.lat);
         end
      end
   end

   task automatic send(input logic [2:0] op, input logic [1:0] sz, input logic [31:0] addr,
                       input logic [3:0] mask, input logic [31:0] data, input logic [7:0] src,
                       input bit lat_chk);
      exp_t e;
      int   t;
      logic err;
      logic [11:0] w;
      a_valid_i = 1; a_opcode_i = op; a_size_i = sz; a_address_i = addr;
      a_mask_i = mask; a_data_i = data; a_source_i = src;
      t = 0;
      @(negedge clk_i);
      while (!a_ready_o && t < 50) begin @(negedge clk_i); t++; end
      if (!a_ready_o) begin
         check("a_ready_timeout", 0, 1);
         a_valid_i = 0;
         return;
      end
      err = !(op == 3'd0 || op == 3'd1 || op == 3'd4) || sz == 2'd3
            || (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'b00)
            || addr[31:14] != 18'h0 || (op == 3'd0 && sz == 2'd2 && mask != 4'hF);
      w = addr[13:2];
      check("mem_req", mem_req_o, !err);
      if (!err) begin
         check("mem_we",    mem_we_o,    op != 3'd4);
         check("mem_addr",  mem_addr_o,  w);
         check("mem_wmask", mem_wmask_o, op == 3'd4 ? 4'h0 : mask);
      end
      e.op = (op == 3'd4) ? 3'd1 : 3'd0;
      e.sz = sz; e.src = src; e.err = err;
      e.data = (!err && op == 3'd4) ? shadow[w] : 32'h0;
      e.lat_chk = lat_chk; e.lat = (!err && op == 3'd4) ? 2 : 1; e.t0 = cyc;
      if (!err && op != 3'd4)
         for (int b = 0; b < 4; b++) if (mask[b]) shadow[w][8*b +: 8] = data[8*b +: 8];
      sb.push_back(e);
      @(posedge clk_i); #1;
      a_valid_i = 0;
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) begin
         sram[i]   = 32'hA500_0000 ^ (i * 32'h0101_0101);
         shadow[i] = 32'hA500_0000 ^ (i * 32'h0101_0101);
      end
      repeat (3) @(negedge clk_i);
      check("rst_a_ready", a_ready_o, 0);
      check("rst_d_valid", d_valid_o, 0);
      check("rst_mem_req", mem_req_o, 0);
      @(posedge clk_i); #1 rst_ni = 1;
      @(posedge clk_i); #1;
      check("post_rst_a_ready", a_ready_o, 1);

      send(3'd4, 2'd2, 32'h10, 4'hF, 32'h0, 8'd3, 1);              // Get
      repeat (3) @(posedge clk_i); #1;
      send(3'd0, 2'd2, 32'h8, 4'hF, 32'hDEADBEEF, 8'd4, 1);         // PutFull
      repeat (2) @(posedge clk_i); #1;
      send(3'd4, 2'd2, 32'h8, 4'hF, 32'h0, 8'd5, 1);                // readback
      send(3'd1, 2'd2, 32'h20, 4'b0010, 32'h1234AB78, 8'd6, 0);     // PutPartial byte1
      send(3'd4, 2'd2, 32'h20, 4'hF, 32'h0, 8'd7, 0);
      repeat (3) @(posedge clk_i); #1;
      send(3'd4, 2'd2, 32'h4002, 4'hF, 32'h0, 8'd8, 1);             // misaligned / out of range
      repeat (2) @(posedge clk_i); #1;
      send(3'd3, 2'd2, 32'h40, 4'hF, 32'h0, 8'd9, 1);               // illegal opcode
      repeat (2) @(posedge clk_i); #1;
      send(3'd0, 2'd2, 32'h44, 4'h7, 32'h0, 8'd10, 0);              // PutFull short mask
      send(3'd4, 2'd1, 32'h46, 4'hC, 32'h0, 8'd11, 0);              // aligned half-word Get
      repeat (3) @(posedge clk_i); #1;

      // Backpressure: two Gets fill the FIFO, third waits for a slot.
      d_ready_i = 0;
      send(3'd4, 2'd2, 32'h100, 4'hF, 32'h0, 8'd20, 0);
      send(3'd4, 2'd2, 32'h104, 4'hF, 32'h0, 8'd21, 0);
      @(negedge clk_i);
      check("a_ready_full", a_ready_o, 0);
      fork
         send(3'd4, 2'd2, 32'h108, 4'hF, 32'h0, 8'd22, 0);
         begin
            repeat (3) @(posedge clk_i); #1 d_ready_i = 1;
            @(negedge clk_i);
            check("a_ready_no_same_cycle", a_ready_o, 0);
         end
      join
      repeat (4) @(posedge clk_i); #1;

      // Reset with two reads outstanding, the second still in flight at the SRAM.
      d_ready_i = 0;
      send(3'd4, 2'd2, 32'h30, 4'hF, 32'h0, 8'd30, 0);
      send(3'd4, 2'd2, 32'h34, 4'hF, 32'h0, 8'd31, 0);
      rst_ni = 0;
      sb.delete();
      @(negedge clk_i);
      check("midrst_d_valid", d_valid_o, 0);
      check("midrst_count", dut.u_fifo.count_q, 0);
      @(posedge clk_i); #1 rst_ni = 1; d_ready_i = 1;
      send(3'd4, 2'd2, 32'h30, 4'hF, 32'h0, 8'd32, 1);
      repeat (3) @(posedge clk_i); #1;

      rnd_on = 1;
      for (int i = 0; i < 24; i++) begin
         logic [2:0]  op;
         logic [31:0] ad;
         logic [3:0]  mk;
         case ($urandom_range(0, 4))
            0: op = 3'd0;
            1: op = 3'd1;
            2: op = 3'd3;
            default: op = 3'd4;
         endcase
         ad = {24'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'b00};
         if ($urandom_range(0, 7) == 0) ad[1] = 1'b1;
         mk = (op == 3'd0) ? 4'hF : 4'($urandom_range(1, 15));
         send(op, 2'd2, ad, mk, $urandom, 8'(40 + i), 0);
      end
      rnd_on = 0;
      #2 d_ready_i = 1;
      for (int t = 0; t < 200 && sb.size() != 0; t++) @(posedge clk_i);
      @(negedge clk_i);
      check("drain", sb.size(), 0);
      check("orphan_rvalid", dut.orphan_q, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
